io_decode_ctrl: RTL and testbench
=================================

Name: io_decode_ctrl

Overview:
- Parametrised, single-clock successor to the Dock I/O address decoder.
- Maps CPU I/O cycles (/IORQ qualified) through NUM_WIN priority-ordered base/mask windows onto NUM_SLOTS active-low chip selects.
- Sequences READY with per-window programmable wait states, device ready stretching and a bus-timeout watchdog.
- Configured through a synchronous byte-wide register bus with readback and a sticky error status.

Parameters:
ADDR_W, 8, I/O address width (8 or 16)
NUM_WIN, 8, number of decode windows (1..15); lower index has higher priority
NUM_SLOTS, 5, number of chip-select outputs (2..8)
WS_W, 4, width of per-window fixed wait-state count

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
addr  in  ADDR_W  CPU I/O address
iorq_n  in  1  I/O request qualifier, active low
r_w_  in  1  1=read, 0=write
dev_ready_n  in  NUM_SLOTS  per-slot device ready; 1=ready, 0=stretch
cfg_we  in  1  config write strobe
cfg_re  in  1  config read strobe
cfg_addr  in  8  {window[7:4], reg[3:0]}; window 0xF = global registers
cfg_wdata  in  8  config write data
cfg_rdata  out  8  config read data, registered
cs_n  out  NUM_SLOTS  one-hot-low chip selects
ready_n  out  1  0=CPU wait, 1=proceed
io_r_w_  out  1  latched direction; 1 when idle
data_oe_n  out  1  data buffer enable, active low
data_dir  out  1  1=device-to-CPU
ff_oe_n  out  1  read-hold latch output enable, active low
win_valid  out  1  combinational: current address/op matches a window
win_index  out  4  combinational index of the winning window
sel_slot  out  3  combinational slot of the winning window
bus_err  out  1  sticky timeout flag (mirror of STATUS[0])

Behaviour:
- Clock and reset:
  - Single clock domain; the configuration bus is synchronous to clk.
  - Reset (async assert, sync deassert by upstream) forces state IDLE.
  - Outputs under reset: cs_n all 1, ready_n=1, io_r_w_=1, data_oe_n=1, data_dir=0, ff_oe_n=1, cfg_rdata=0, bus_err=0.
  - Window register resets: base=0, mask=0, slot=0, op=0x03, ws=0, enable=0. TIMEOUT=0 (watchdog disabled).
- Per-window register map, reg n:
  - 0/1 = base lo/hi; 2/3 = mask lo/hi (hi ignored when ADDR_W=8).
  - 4 = {enable[7], slot[2:0]}.
  - 5 = op: bit0 read allowed, bit1 write allowed.
  - 6 = ws[WS_W-1:0].
  - Unused bits read 0.
- Global registers (window 0xF): reg0 TIMEOUT (8 bit); reg1 STATUS, bit0 bus_err, write-1-to-clear; reg2/3 ERR_ADDR lo/hi (read-only).
- Register access:
  - Writes land on the edge where cfg_we=1. Writes to out-of-range windows are ignored.
  - cfg_rdata is valid on the edge following cfg_re=1; out-of-range reads return 0x00.
- Match rule: enable && ((addr ^ base) & mask)==0 && op bit for r_w_ set. The lowest matching index wins. Slot values >= NUM_SLOTS never match.
- State IDLE:
  - On an edge with iorq_n=0 and win_valid: latch slot, r_w_, addr; load wait counter=ws; clear timeout counter; go to ACTIVE.
  - Outputs from that edge: cs_n[slot]=0, ready_n=0, io_r_w_=r_w_, data_oe_n=0, data_dir=r_w_.
  - iorq_n=0 with no match: go to NOMATCH. No cs is asserted and ready_n stays 1.
- State ACTIVE:
  - If wait counter>0, decrement and hold ready_n=0.
  - Else, if dev_ready_n[slot]=1, go to READY.
  - The timeout counter increments every ACTIVE cycle. If TIMEOUT!=0 and counter==TIMEOUT, go to ERR instead.
  - Zero-wait-state latency: ready_n rises exactly one edge after entry.
- State READY: ready_n=1; cs held; ff_oe_n=0 when the cycle is a read.
- State ERR:
  - cs_n all 1, ready_n=1, data_oe_n=1.
  - STATUS[0] set; ERR_ADDR loaded with the latched address.
  - A set and a write-1-clear in the same cycle leave the bit set.
- Leaving a cycle: ACTIVE, READY, ERR and NOMATCH all return to IDLE on the first edge sampling iorq_n=1. Outputs return to their reset values at that same edge.
  - iorq_n=1 during ACTIVE is an abort: no error is flagged.
- Config changes during a cycle do not affect the latched slot or direction; they apply to the next decode. Decode in the same cycle as a cfg write uses the pre-write values.
- Counter limits: the wait counter saturates at 0; the timeout counter does not wrap (compare happens before increment).

Test Plan:
- Win0 base=0x10 mask=0xF0 slot1 en; Win3 mask=0x00 slot4 en. Read 0x10, then 0x70 -> cs=00010, then 10000. ready_n=0 at entry, 1 on next edge; tail cs=00000, io_r_w_=1.
- Win0 op=0x01. Write to 0x10 -> falls through to Win3, cs=10000. Read to 0x10 -> cs=00010.
- Win1=0x20/0xF0 slot2 ws=3, dev ready -> ready_n low for 4 edges after entry. Additionally hold dev_ready_n[2]=0 for 2 extra cycles -> ready_n low for 6 edges.
- TIMEOUT=5, dev_ready_n[2] held 0 at 0x23 -> ERR after 5 ACTIVE cycles: cs released, ready_n=1, STATUS=0x01, ERR_ADDR=0x23. Write STATUS=0x01 -> cleared.
- Windows 0 and 1 overlap at 0x10, slot1 vs slot0 -> Win0 wins (cs=00010). Addr 0x50 with Win3 disabled -> NOMATCH, cs=00000, ready_n=1 throughout.
- rst_n pulsed low mid-ACTIVE -> all outputs immediately return to reset values. Readback of win0 reg4 = 0x00.

Source files
------------

// File: rtl/io_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : io_decode_ctrl
// Brief    : CPU I/O address decoder. Priority-ordered base/mask windows map
//            /IORQ cycles onto active-low chip selects, sequence READY with
//            programmable wait states, device stretch and a bus watchdog,
//            and expose a byte-wide configuration/status register bus.
// Revision : 1.0 - initial release
// ============================================================================
module io_decode_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int NUM_WIN   = 8,
    parameter int NUM_SLOTS = 5,
    parameter int WS_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 iorq_n,
    input  logic                 r_w_,
    input  logic [NUM_SLOTS-1:0] dev_ready_n,
    input  logic                 cfg_we,
    input  logic                 cfg_re,
    input  logic [7:0]           cfg_addr,
    input  logic [7:0]           cfg_wdata,
    output logic [7:0]           cfg_rdata,
    output logic [NUM_SLOTS-1:0] cs_n,
    output logic                 ready_n,
    output logic                 io_r_w_,
    output logic                 data_oe_n,
    output logic                 data_dir,
    output logic                 ff_oe_n,
    output logic                 win_valid,
    output logic [3:0]           win_index,
    output logic [2:0]           sel_slot,
    output logic                 bus_err
);

    // Address bits that exist on this bus, expressed on a 16-bit register view
    localparam logic [15:0]          c_AMASK = 16'((32'h1 << ADDR_W) - 32'h1);
    localparam logic [NUM_SLOTS-1:0] c_ONE   = NUM_SLOTS'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACTIVE  = 3'd1,
        S_READY   = 3'd2,
        S_ERR     = 3'd3,
        S_NOMATCH = 3'd4
    } state_t;

    // Window configuration storage
    logic [15:0]        base_q [NUM_WIN];
    logic [15:0]        mask_q [NUM_WIN];
    logic [2:0]         slot_q [NUM_WIN];
    logic [1:0]         op_q   [NUM_WIN];
    logic [WS_W-1:0]    ws_q   [NUM_WIN];
    logic [NUM_WIN-1:0] en_q;

    // Global registers
    logic [7:0]  timeout_q;
    logic        status_q;
    logic [15:0] err_addr_q;
    logic [7:0]  rdata_q;
    logic [7:0]  rdata_d;

    // Cycle sequencing state
    state_t          state_q, state_d;
    logic [2:0]      cur_slot_q, cur_slot_d;
    logic            rw_q, rw_d;
    logic [15:0]     lat_addr_q, lat_addr_d;
    logic [WS_W-1:0] wcnt_q, wcnt_d;
    logic [7:0]      tcnt_q, tcnt_d;

    logic [15:0]        addr_ext;
    logic [3:0]         cfg_win;
    logic [3:0]         cfg_reg;
    logic               cfg_glb;
    logic               cfg_win_ok;
    logic [NUM_WIN-1:0] hit;
    logic [WS_W-1:0]    win_ws;
    logic               err_set;

    assign addr_ext   = 16'(addr);
    assign cfg_win    = cfg_addr[7:4];
    assign cfg_reg    = cfg_addr[3:0];
    assign cfg_glb    = (cfg_win == 4'hF);
    assign cfg_win_ok = ({28'd0, cfg_win} < 32'(NUM_WIN));
    assign err_set    = (state_q == S_ACTIVE) && (state_d == S_ERR);
    assign cfg_rdata  = rdata_q;
    assign bus_err    = status_q;

    // Window register writes; high bytes keep only bits that exist on the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                base_q[i] <= '0;
                mask_q[i] <= '0;
                slot_q[i] <= '0;
                op_q[i]   <= 2'b11;
                ws_q[i]   <= '0;
            end
            en_q <= '0;
        end else if (cfg_we && cfg_win_ok) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                if (cfg_win == 4'(i)) begin
                    case (cfg_reg)
                        4'd0: base_q[i][7:0]  <= cfg_wdata;
                        4'd1: base_q[i][15:8] <= cfg_wdata & c_AMASK[15:8];
                        4'd2: mask_q[i][7:0]  <= cfg_wdata;
                        4'd3: mask_q[i][15:8] <= cfg_wdata & c_AMASK[15:8];
                        4'd4: begin
                            en_q[i]   <= cfg_wdata[7];
                            slot_q[i] <= cfg_wdata[2:0];
                        end
                        4'd5: op_q[i] <= cfg_wdata[1:0];
                        4'd6: ws_q[i] <= cfg_wdata[WS_W-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Watchdog limit, sticky error flag (set beats clear) and error address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q  <= 8'h00;
            status_q   <= 1'b0;
            err_addr_q <= 16'h0000;
        end else begin
            if (cfg_we && cfg_glb && (cfg_reg == 4'd0)) begin
                timeout_q <= cfg_wdata;
            end
            if (err_set) begin
                status_q   <= 1'b1;
                err_addr_q <= lat_addr_q;
            end else if (cfg_we && cfg_glb && (cfg_reg == 4'd1) && cfg_wdata[0]) begin
                status_q <= 1'b0;
            end
        end
    end

    // Readback mux; unmapped registers and windows read as zero
    always_comb begin
        rdata_d = 8'h00;
        if (cfg_glb) begin
            case (cfg_reg)
                4'd0:    rdata_d = timeout_q;
                4'd1:    rdata_d = {7'd0, status_q};
                4'd2:    rdata_d = err_addr_q[7:0];
                4'd3:    rdata_d = err_addr_q[15:8];
                default: rdata_d = 8'h00;
            endcase
        end else if (cfg_win_ok) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                if (cfg_win == 4'(i)) begin
                    case (cfg_reg)
                        4'd0:    rdata_d = base_q[i][7:0];
                        4'd1:    rdata_d = base_q[i][15:8];
                        4'd2:    rdata_d = mask_q[i][7:0];
                        4'd3:    rdata_d = mask_q[i][15:8];
                        4'd4:    rdata_d = {en_q[i], 4'd0, slot_q[i]};
                        4'd5:    rdata_d = {6'd0, op_q[i]};
                        4'd6:    rdata_d = 8'(ws_q[i]);
                        default: rdata_d = 8'h00;
                    endcase
                end
            end
        end
    end

    // Registered read data, updated only on a read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 8'h00;
        end else if (cfg_re) begin
            rdata_q <= rdata_d;
        end
    end

    // Per-window match: enabled, address under mask, direction allowed, slot exists
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            hit[i] = en_q[i]
                  && (((addr_ext ^ base_q[i]) & mask_q[i] & c_AMASK) == 16'h0000)
                  && (r_w_ ? op_q[i][0] : op_q[i][1])
                  && (32'(slot_q[i]) < 32'(NUM_SLOTS));
        end
    end

    // Priority select: scanning downward leaves the lowest matching index
    always_comb begin
        win_valid = 1'b0;
        win_index = 4'd0;
        sel_slot  = 3'd0;
        win_ws    = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_valid = 1'b1;
                win_index = 4'(i);
                sel_slot  = slot_q[i];
                win_ws    = ws_q[i];
            end
        end
    end

    // Cycle state and latched cycle attributes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_slot_q <= 3'd0;
            rw_q       <= 1'b1;
            lat_addr_q <= 16'h0000;
            wcnt_q     <= '0;
            tcnt_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            cur_slot_q <= cur_slot_d;
            rw_q       <= rw_d;
            lat_addr_q <= lat_addr_d;
            wcnt_q     <= wcnt_d;
            tcnt_q     <= tcnt_d;
        end
    end

    // Next state: watchdog is checked before the counter advances
    always_comb begin
        state_d    = state_q;
        cur_slot_d = cur_slot_q;
        rw_d       = rw_q;
        lat_addr_d = lat_addr_q;
        wcnt_d     = wcnt_q;
        tcnt_d     = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (!iorq_n) begin
                    if (win_valid) begin
                        state_d    = S_ACTIVE;
                        cur_slot_d = sel_slot;
                        rw_d       = r_w_;
                        lat_addr_d = addr_ext;
                        wcnt_d     = win_ws;
                        tcnt_d     = 8'h00;
                    end else begin
                        state_d = S_NOMATCH;
                    end
                end
            end
            S_ACTIVE: begin
                if (iorq_n) begin
                    state_d = S_IDLE;
                end else if ((timeout_q != 8'h00) && (tcnt_q == timeout_q)) begin
                    state_d = S_ERR;
                end else begin
                    if (tcnt_q != 8'hFF) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                    if (wcnt_q != '0) begin
                        wcnt_d = wcnt_q - 1'b1;
                    end else if (dev_ready_n[cur_slot_q]) begin
                        state_d = S_READY;
                    end
                end
            end
            default: begin
                if (iorq_n) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Bus outputs decoded from the current state; idle values double as reset values
    always_comb begin
        cs_n      = '1;
        ready_n   = 1'b1;
        io_r_w_   = 1'b1;
        data_oe_n = 1'b1;
        data_dir  = 1'b0;
        ff_oe_n   = 1'b1;
        case (state_q)
            S_ACTIVE: begin
                cs_n      = ~(c_ONE << cur_slot_q);
                ready_n   = 1'b0;
                io_r_w_   = rw_q;
                data_oe_n = 1'b0;
                data_dir  = rw_q;
            end
            S_READY: begin
                cs_n      = ~(c_ONE << cur_slot_q);
                io_r_w_   = rw_q;
                data_oe_n = 1'b0;
                data_dir  = rw_q;
                ff_oe_n   = ~rw_q;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_io_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_decode_ctrl
// Brief    : Self-checking bench for io_decode_ctrl: directed scenarios with
//            literal expectations plus randomized I/O and config traffic
//            compared every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_decode_ctrl;

    localparam int ADDR_W    = 8;
    localparam int NUM_WIN   = 8;
    localparam int NUM_SLOTS = 5;
    localparam int WS_W      = 4;
    localparam int AMASK     = (1 << ADDR_W) - 1;
    localparam int SMASK     = (1 << NUM_SLOTS) - 1;

    // Model cycle phases
    localparam int P_IDLE = 0;
    localparam int P_ACT  = 1;
    localparam int P_RDY  = 2;
    localparam int P_ERR  = 3;
    localparam int P_NOM  = 4;

    logic                 clk         = 1'b0;
    logic                 rst_n       = 1'b0;
    logic [ADDR_W-1:0]    addr        = '0;
    logic                 iorq_n      = 1'b1;
    logic                 r_w_        = 1'b1;
    logic [NUM_SLOTS-1:0] dev_ready_n = '1;
    logic                 cfg_we      = 1'b0;
    logic                 cfg_re      = 1'b0;
    logic [7:0]           cfg_addr    = 8'h00;
    logic [7:0]           cfg_wdata   = 8'h00;
    logic [7:0]           cfg_rdata;
    logic [NUM_SLOTS-1:0] cs_n;
    logic                 ready_n, io_r_w_, data_oe_n, data_dir, ff_oe_n;
    logic                 win_valid, bus_err;
    logic [3:0]           win_index;
    logic [2:0]           sel_slot;

    io_decode_ctrl #(
        .ADDR_W(ADDR_W), .NUM_WIN(NUM_WIN), .NUM_SLOTS(NUM_SLOTS), .WS_W(WS_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .iorq_n(iorq_n), .r_w_(r_w_),
        .dev_ready_n(dev_ready_n), .cfg_we(cfg_we), .cfg_re(cfg_re),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .cs_n(cs_n), .ready_n(ready_n), .io_r_w_(io_r_w_), .data_oe_n(data_oe_n),
        .data_dir(data_dir), .ff_oe_n(ff_oe_n), .win_valid(win_valid),
        .win_index(win_index), .sel_slot(sel_slot), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_base [NUM_WIN];
    int m_mask [NUM_WIN];
    int m_slot [NUM_WIN];
    int m_op   [NUM_WIN];
    int m_ws   [NUM_WIN];
    int m_en   [NUM_WIN];
    int m_tmo, m_err, m_eaddr, m_rdata;
    int m_ph, m_cslot, m_crw, m_caddr, m_cws, m_age;

    function automatic void model_reset();
        for (int i = 0; i < NUM_WIN; i++) begin
            m_base[i] = 0; m_mask[i] = 0; m_slot[i] = 0;
            m_op[i] = 3; m_ws[i] = 0; m_en[i] = 0;
        end
        m_tmo = 0; m_err = 0; m_eaddr = 0; m_rdata = 0;
        m_ph = P_IDLE; m_cslot = 0; m_crw = 1; m_caddr = 0; m_cws = 0; m_age = 0;
    endfunction

    // Lowest-index window whose rule holds, or -1
    function automatic int decode(input int a, input int rw);
        for (int i = 0; i < NUM_WIN; i++) begin
            if (m_en[i] != 0 && ((a ^ m_base[i]) & m_mask[i] & AMASK) == 0 &&
                ((m_op[i] >> ((rw != 0) ? 0 : 1)) & 1) == 1 && m_slot[i] < NUM_SLOTS)
                return i;
        end
        return -1;
    endfunction

    function automatic int model_read(input int w, input int r);
        if (w == 15) begin
            case (r)
                0: return m_tmo;
                1: return m_err;
                2: return m_eaddr & 8'hFF;
                3: return (m_eaddr >> 8) & 8'hFF;
                default: return 0;
            endcase
        end
        if (w >= NUM_WIN) return 0;
        case (r)
            0: return m_base[w] & 8'hFF;
            1: return (m_base[w] >> 8) & 8'hFF;
            2: return m_mask[w] & 8'hFF;
            3: return (m_mask[w] >> 8) & 8'hFF;
            4: return (m_en[w] << 7) | m_slot[w];
            5: return m_op[w];
            6: return m_ws[w];
            default: return 0;
        endcase
    endfunction

    function automatic void model_write(input int w, input int r, input int d);
        if (w == 15) begin
            if (r == 0) m_tmo = d;
            if (r == 1 && (d & 1) == 1) m_err = 0;
            return;
        end
        if (w >= NUM_WIN) return;
        case (r)
            0: m_base[w] = (m_base[w] & 32'hFF00) | d;
            1: m_base[w] = ((d << 8) & AMASK) | (m_base[w] & 8'hFF);
            2: m_mask[w] = (m_mask[w] & 32'hFF00) | d;
            3: m_mask[w] = ((d << 8) & AMASK) | (m_mask[w] & 8'hFF);
            4: begin m_en[w] = (d >> 7) & 1; m_slot[w] = d & 7; end
            5: m_op[w] = d & 3;
            6: m_ws[w] = d & ((1 << WS_W) - 1);
            default: ;
        endcase
    endfunction

    // Model advance on every clock edge; reads and decodes see pre-write config
    always @(posedge clk or negedge rst_n) begin
        int hit;
        int set_err;
        int tc;
        if (!rst_n) begin
            model_reset();
        end else begin
            set_err = 0;
            if (cfg_re) m_rdata = model_read(int'(cfg_addr[7:4]), int'(cfg_addr[3:0]));
            case (m_ph)
                P_IDLE: if (!iorq_n) begin
                    hit = decode(int'(addr), int'(r_w_));
                    if (hit >= 0) begin
                        m_ph = P_ACT; m_cslot = m_slot[hit]; m_crw = int'(r_w_);
                        m_caddr = int'(addr); m_cws = m_ws[hit]; m_age = 0;
                    end else begin
                        m_ph = P_NOM;
                    end
                end
                P_ACT: begin
                    tc = (m_age > 255) ? 255 : m_age;
                    if (iorq_n) m_ph = P_IDLE;
                    else if (m_tmo != 0 && tc == m_tmo) begin m_ph = P_ERR; set_err = 1; end
                    else begin
                        if (m_age >= m_cws && dev_ready_n[m_cslot] == 1'b1) m_ph = P_RDY;
                        m_age++;
                    end
                end
                default: if (iorq_n) m_ph = P_IDLE;
            endcase
            if (cfg_we) model_write(int'(cfg_addr[7:4]), int'(cfg_addr[3:0]), int'(cfg_wdata));
            if (set_err != 0) begin m_err = 1; m_eaddr = m_caddr; end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(posedge clk) begin
        int eh, e_cs, e_rdy, e_rw, e_oe, e_dir, e_ff;
        #2;
        if (rst_n) begin
            eh = decode(int'(addr), int'(r_w_));
            chk("win_valid", win_valid, (eh >= 0) ? 1 : 0);
            if (eh >= 0) begin
                chk("win_index", win_index, eh);
                chk("sel_slot", sel_slot, m_slot[eh]);
            end
            e_cs = SMASK; e_rdy = 1; e_rw = 1; e_oe = 1; e_dir = 0; e_ff = 1;
            if (m_ph == P_ACT || m_ph == P_RDY) begin
                e_cs  = ~(1 << m_cslot) & SMASK;
                e_rdy = (m_ph == P_RDY) ? 1 : 0;
                e_rw  = m_crw; e_oe = 0; e_dir = m_crw;
                e_ff  = (m_ph == P_RDY && m_crw == 1) ? 0 : 1;
            end
            chk("cs_n", cs_n, e_cs);
            chk("ready_n", ready_n, e_rdy);
            chk("io_r_w_", io_r_w_, e_rw);
            chk("data_oe_n", data_oe_n, e_oe);
            chk("data_dir", data_dir, e_dir);
            chk("ff_oe_n", ff_oe_n, e_ff);
            chk("bus_err", bus_err, m_err);
            chk("cfg_rdata", cfg_rdata, m_rdata);
        end
    end

    // ---------------- stimulus helpers (enter and leave on a falling edge) ----------------
    task automatic cfg_wr(input logic [7:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic cfg_rd_chk(input string nm, input logic [7:0] a, input logic [7:0] e);
        cfg_re = 1'b1; cfg_addr = a;
        @(negedge clk);
        cfg_re = 1'b0;
        chk(nm, cfg_rdata, e);
    endtask

    task automatic io_begin(input logic [7:0] a, input logic rw);
        iorq_n = 1'b0; addr = a; r_w_ = rw;
        @(negedge clk);
    endtask

    task automatic io_end();
        iorq_n = 1'b1;
        @(negedge clk);
    endtask

    // Counts falling edges with ready_n low; device stall lifts at edge release_at
    task automatic count_low(input int release_at, output int n);
        n = 0;
        while (ready_n == 1'b0 && n < 50) begin
            n++;
            if (n == release_at) dev_ready_n = '1;
            @(negedge clk);
        end
    endtask

    logic [7:0] masks [6] = '{8'hF0, 8'hF8, 8'hC0, 8'h00, 8'hFF, 8'hE0};

    initial begin
        int n;
        int hold;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 5'h1F);
        chk("rst_ready_n", ready_n, 1);
        chk("rst_io_r_w_", io_r_w_, 1);
        chk("rst_data_oe_n", data_oe_n, 1);
        chk("rst_data_dir", data_dir, 0);
        chk("rst_ff_oe_n", ff_oe_n, 1);
        chk("rst_cfg_rdata", cfg_rdata, 0);
        chk("rst_bus_err", bus_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Win0 0x10/F0 slot1, Win3 catch-all slot4
        cfg_wr(8'h00, 8'h10); cfg_wr(8'h02, 8'hF0); cfg_wr(8'h04, 8'h81);
        cfg_wr(8'h32, 8'h00); cfg_wr(8'h34, 8'h84);
        io_begin(8'h10, 1'b1);
        chk("rd10_cs", cs_n, 5'b11101);
        chk("rd10_ready_entry", ready_n, 0);
        @(negedge clk);
        chk("rd10_ready_next", ready_n, 1);
        chk("rd10_ff_oe", ff_oe_n, 0);
        io_end();
        chk("tail_cs", cs_n, 5'h1F);
        chk("tail_rw", io_r_w_, 1);
        io_begin(8'h70, 1'b1);
        chk("rd70_cs", cs_n, 5'b01111);
        @(negedge clk);
        io_end();

        // Win0 read-only: write falls through to Win3
        cfg_wr(8'h05, 8'h01);
        io_begin(8'h10, 1'b0);
        chk("wr10_cs", cs_n, 5'b01111);
        chk("wr10_dir", io_r_w_, 0);
        io_end();
        io_begin(8'h10, 1'b1);
        chk("rd10b_cs", cs_n, 5'b11101);
        io_end();

        // Win1 0x20/F0 slot2 ws=3
        cfg_wr(8'h10, 8'h20); cfg_wr(8'h12, 8'hF0); cfg_wr(8'h14, 8'h82); cfg_wr(8'h16, 8'h03);
        io_begin(8'h20, 1'b1);
        count_low(0, n);
        chk("ws3_low_edges", n, 4);
        io_end();
        dev_ready_n = 5'b11011;
        io_begin(8'h20, 1'b1);
        count_low(6, n);
        chk("ws3_stall_low_edges", n, 6);
        io_end();

        // Watchdog
        cfg_wr(8'hF0, 8'h05);
        dev_ready_n = 5'b11011;
        io_begin(8'h23, 1'b1);
        n = 0;
        while (ready_n == 1'b0 && n < 50) begin n++; @(negedge clk); end
        chk("to_reached", (n < 50) ? 1 : 0, 1);
        chk("err_cs", cs_n, 5'h1F);
        chk("err_oe", data_oe_n, 1);
        chk("err_flag", bus_err, 1);
        io_end();
        dev_ready_n = '1;
        cfg_rd_chk("status", 8'hF1, 8'h01);
        cfg_rd_chk("err_addr", 8'hF2, 8'h23);
        cfg_wr(8'hF1, 8'h01);
        cfg_rd_chk("status_clr", 8'hF1, 8'h00);
        cfg_wr(8'hF0, 8'h00);

        // Overlap: Win1 moved onto 0x10 with slot0; Win0 must still win
        cfg_wr(8'h10, 8'h10); cfg_wr(8'h14, 8'h80);
        addr = 8'h10; r_w_ = 1'b1;
        #1;
        chk("ovl_index", win_index, 0);
        io_begin(8'h10, 1'b1);
        chk("ovl_cs", cs_n, 5'b11101);
        io_end();

        // No match with Win3 disabled
        cfg_wr(8'h34, 8'h04);
        io_begin(8'h50, 1'b1);
        chk("nm_valid", win_valid, 0);
        chk("nm_cs", cs_n, 5'h1F);
        chk("nm_ready", ready_n, 1);
        @(negedge clk);
        chk("nm_ready2", ready_n, 1);
        io_end();

        // Asynchronous reset in the middle of a wait-stated cycle (Win1, slot0)
        io_begin(8'h10, 1'b0);
        chk("pre_rst_cs", cs_n, 5'b11110);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cs_n", cs_n, 5'h1F);
        chk("arst_ready_n", ready_n, 1);
        chk("arst_io_r_w_", io_r_w_, 1);
        chk("arst_data_oe_n", data_oe_n, 1);
        chk("arst_data_dir", data_dir, 0);
        chk("arst_ff_oe_n", ff_oe_n, 1);
        iorq_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cfg_rd_chk("win0_reg4_rst", 8'h04, 8'h00);

        // Randomized configuration
        for (int i = 0; i < NUM_WIN; i++) begin
            cfg_wr({4'(i), 4'h0}, 8'($urandom));
            cfg_wr({4'(i), 4'h2}, masks[$urandom_range(0, 5)]);
            cfg_wr({4'(i), 4'h4}, {1'($urandom_range(0, 3) != 0), 4'd0, 3'($urandom_range(0, 7))});
            cfg_wr({4'(i), 4'h5}, 8'($urandom_range(0, 3)));
            cfg_wr({4'(i), 4'h6}, 8'($urandom_range(0, 3)));
        end
        cfg_wr(8'hF0, 8'($urandom_range(0, 1) * $urandom_range(3, 10)));

        // Randomized I/O cycles with concurrent config traffic
        for (int t = 0; t < 250; t++) begin
            hold   = $urandom_range(1, 12);
            addr   = 8'($urandom);
            r_w_   = 1'($urandom);
            iorq_n = ($urandom_range(0, 5) != 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < hold; k++) begin
                for (int b = 0; b < NUM_SLOTS; b++) dev_ready_n[b] = ($urandom_range(0, 3) != 0);
                cfg_re    = 1'($urandom);
                cfg_addr  = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 7))};
                cfg_we    = ($urandom_range(0, 7) == 0);
                cfg_wdata = 8'($urandom);
                if (cfg_we && cfg_addr[7:4] == 4'hF && cfg_addr[3:0] == 4'h0)
                    cfg_wdata = 8'($urandom_range(0, 8));
                @(negedge clk);
            end
            cfg_we = 1'b0; cfg_re = 1'b0; iorq_n = 1'b1;
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Run-length guard
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1);
    end

endmodule
`default_nettype wire
